e203_ifu_flush_rsp: RTL and testbench

Responder side of the commit-stage pipeline flush handshake, located in the IFU. It accepts `pipe_flush_req` carrying the target operands from the commit/branch-resolve logic and computes the redirect PC. It then drains outstanding instruction-fetch bus transactions, dropping their stale responses, and issues a single-cycle fetch redirect.

---
 rtl/e203_ifu_flush_rsp_pkg.sv | 21 ++
 rtl/e203_ifu_flush_rsp_chk.sv | 24 ++
 rtl/e203_ifu_outs_cnt.sv | 65 ++++++
 rtl/e203_ifu_flush_rsp.sv | 157 +++++++++++++++
 tb/tb_e203_ifu_flush_rsp.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/e203_ifu_flush_rsp_pkg.sv
// ----------------------------------------------------------------------------
// e203_ifu_flush_rsp_pkg
// Shared definitions for the IFU flush responder:
//   E203_PC_SIZE   - default fetch PC width
//   E203_OUTS_W    - default outstanding-fetch counter width
//   E203_OUTS_MAX  - largest outstanding count for the default width
//   flush_state_e  - responder states (IDLE=0, DRAIN=1, REDIR=2)
// ----------------------------------------------------------------------------
package e203_ifu_flush_rsp_pkg;

    localparam int E203_PC_SIZE  = 32;
    localparam int E203_OUTS_W   = 2;
    localparam int E203_OUTS_MAX = (1 << E203_OUTS_W) - 1;

    typedef enum logic [1:0] {
        FLUSH_IDLE  = 2'd0,
        FLUSH_DRAIN = 2'd1,
        FLUSH_REDIR = 2'd2
    } flush_state_e;

endpackage

// File: rtl/e203_ifu_flush_rsp_chk.sv
// ----------------------------------------------------------------------------
// e203_ifu_flush_rsp_chk
// Protocol checker: a fetch response must never arrive while no fetch is
// outstanding.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   rsp_valid   - fetch response strobe
//   outs_cnt    - current outstanding count
// ----------------------------------------------------------------------------
module e203_ifu_flush_rsp_chk #(
    parameter int OUTS_W = 2
) (
    input logic              clk,
    input logic              rst_n,
    input logic              rsp_valid,
    input logic [OUTS_W-1:0] outs_cnt
);

    rsp_without_outstanding_a: assert property (
        @(posedge clk) disable iff (!rst_n)
        rsp_valid |-> (outs_cnt != {OUTS_W{1'b0}})
    );

endmodule

// File: rtl/e203_ifu_outs_cnt.sv
// ----------------------------------------------------------------------------
// e203_ifu_outs_cnt
// Up/down saturating counter of outstanding instruction-fetch transactions.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   inc         - request accepted by the bus this cycle
//   dec         - response returned this cycle
//   cnt         - current outstanding count
//   cnt_nxt     - count that will be held next cycle
//   full        - count is at its maximum (2^OUTS_W-1)
// ----------------------------------------------------------------------------
module e203_ifu_outs_cnt #(
    parameter int OUTS_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              dec,
    output logic [OUTS_W-1:0] cnt,
    output logic [OUTS_W-1:0] cnt_nxt,
    output logic              full
);

    localparam logic [OUTS_W-1:0] CNT_MAX  = {OUTS_W{1'b1}};
    localparam logic [OUTS_W-1:0] CNT_ZERO = {OUTS_W{1'b0}};
    localparam logic [OUTS_W-1:0] CNT_ONE  = CNT_ZERO + OUTS_W'(1);

    logic [OUTS_W-1:0] cnt_r;
    logic [OUTS_W-1:0] cnt_nxt_s;

    // Next count: simultaneous inc/dec cancel; both ends saturate so a
    // stray response at zero cannot wrap the count to max.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (inc && !dec) begin
            if (cnt_r != CNT_MAX) begin
                cnt_nxt_s = cnt_r + CNT_ONE;
            end else begin
                cnt_nxt_s = cnt_r;
            end
        end else if (dec && !inc) begin
            if (cnt_r != CNT_ZERO) begin
                cnt_nxt_s = cnt_r - CNT_ONE;
            end else begin
                cnt_nxt_s = cnt_r;
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= CNT_ZERO;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    assign cnt     = cnt_r;
    assign cnt_nxt = cnt_nxt_s;
    assign full    = (cnt_r == CNT_MAX);

endmodule

// File: rtl/e203_ifu_flush_rsp.sv
// ----------------------------------------------------------------------------
// e203_ifu_flush_rsp
// IFU responder of the commit-stage flush handshake. Accepts a flush, drains
// outstanding fetches (dropping their responses) and issues a one-cycle
// redirect to the flush target.
// Build option: E203_IFU_FLUSH_PC_IN_EN - when defined, the target is taken
// from pipe_flush_pc instead of op1+op2 (port exists only in that build).
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   pipe_flush_req/ack         - flush handshake (fires on req & ack)
//   pipe_flush_add_op1/op2     - target addends
//   pipe_flush_pc              - precomputed target (option only)
//   ifu_req_valid_raw          - fetch unit request
//   ifu_req_valid/ready        - gated bus request handshake
//   ifu_rsp_valid              - bus response (always consumed)
//   ifu_rsp_drop               - discard the current response
//   redirect_valid/pc          - one-cycle fetch redirect
//   flush_busy                 - responder not idle
// ----------------------------------------------------------------------------
module e203_ifu_flush_rsp
    import e203_ifu_flush_rsp_pkg::*;
#(
    parameter int PC_SIZE = E203_PC_SIZE,
    parameter int OUTS_W  = E203_OUTS_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pipe_flush_req,
    output logic               pipe_flush_ack,
    input  logic [PC_SIZE-1:0] pipe_flush_add_op1,
    input  logic [PC_SIZE-1:0] pipe_flush_add_op2,
`ifdef E203_IFU_FLUSH_PC_IN_EN
    input  logic [PC_SIZE-1:0] pipe_flush_pc,
`endif
    input  logic               ifu_req_valid_raw,
    output logic               ifu_req_valid,
    input  logic               ifu_req_ready,
    input  logic               ifu_rsp_valid,
    output logic               ifu_rsp_drop,
    output logic               redirect_valid,
    output logic [PC_SIZE-1:0] redirect_pc,
    output logic               flush_busy
);

    flush_state_e      state_r;
    flush_state_e      state_nxt_s;
    logic [PC_SIZE-1:0] tgt_r;
    logic [PC_SIZE-1:0] tgt_s;
    logic               redirect_valid_r;
    logic               flush_busy_r;
    logic               flush_hsk_s;
    logic               req_fire_s;
    logic [OUTS_W-1:0]  outs_cnt_s;
    logic [OUTS_W-1:0]  outs_cnt_nxt_s;
    logic               outs_full_s;

    assign pipe_flush_ack = (state_r != FLUSH_REDIR);
    assign flush_hsk_s    = pipe_flush_req & pipe_flush_ack;
    // A pending flush blocks new fetches so the IDLE handshake cycle never
    // adds to the count it is about to drain.
    assign ifu_req_valid  = ifu_req_valid_raw & (state_r == FLUSH_IDLE)
                          & ~pipe_flush_req & ~outs_full_s;
    assign req_fire_s     = ifu_req_valid & ifu_req_ready;
    assign ifu_rsp_drop   = ifu_rsp_valid & ((state_r == FLUSH_DRAIN)
                          | ((state_r == FLUSH_IDLE) & flush_hsk_s));

`ifdef E203_IFU_FLUSH_PC_IN_EN
    logic unused_ops_s;
    assign unused_ops_s = ^{pipe_flush_add_op1, pipe_flush_add_op2};
    assign tgt_s        = {pipe_flush_pc[PC_SIZE-1:1], 1'b0};
`else
    logic [PC_SIZE-1:0] tgt_sum_s;
    assign tgt_sum_s = pipe_flush_add_op1 + pipe_flush_add_op2;
    assign tgt_s     = {tgt_sum_s[PC_SIZE-1:1], 1'b0};
`endif

    e203_ifu_outs_cnt #(
        .OUTS_W (OUTS_W)
    ) u_outs_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (req_fire_s),
        .dec     (ifu_rsp_valid),
        .cnt     (outs_cnt_s),
        .cnt_nxt (outs_cnt_nxt_s),
        .full    (outs_full_s)
    );

    e203_ifu_flush_rsp_chk #(
        .OUTS_W (OUTS_W)
    ) u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .rsp_valid (ifu_rsp_valid),
        .outs_cnt  (outs_cnt_s)
    );

    // Next-state: drain until the count reaches zero, then one redirect cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            FLUSH_IDLE: begin
                if (flush_hsk_s) begin
                    if (outs_cnt_nxt_s == {OUTS_W{1'b0}}) begin
                        state_nxt_s = FLUSH_REDIR;
                    end else begin
                        state_nxt_s = FLUSH_DRAIN;
                    end
                end else begin
                    state_nxt_s = FLUSH_IDLE;
                end
            end
            FLUSH_DRAIN: begin
                if (outs_cnt_nxt_s == {OUTS_W{1'b0}}) begin
                    state_nxt_s = FLUSH_REDIR;
                end else begin
                    state_nxt_s = FLUSH_DRAIN;
                end
            end
            FLUSH_REDIR: begin
                state_nxt_s = FLUSH_IDLE;
            end
            default: begin
                state_nxt_s = FLUSH_IDLE;
            end
        endcase
    end

    // State register plus registered redirect/busy outputs derived from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r          <= FLUSH_IDLE;
            redirect_valid_r <= 1'b0;
            flush_busy_r     <= 1'b0;
        end else begin
            state_r          <= state_nxt_s;
            redirect_valid_r <= (state_nxt_s == FLUSH_REDIR);
            flush_busy_r     <= (state_nxt_s != FLUSH_IDLE);
        end
    end

    // Target register: every accepted flush overwrites it, so the last one wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_r <= {PC_SIZE{1'b0}};
        end else if (flush_hsk_s) begin
            tgt_r <= tgt_s;
        end else begin
            tgt_r <= tgt_r;
        end
    end

    assign redirect_valid = redirect_valid_r;
    assign redirect_pc    = tgt_r;
    assign flush_busy     = flush_busy_r;

endmodule

// File: tb/tb_e203_ifu_flush_rsp.sv
module tb_e203_ifu_flush_rsp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_flush_req;
    logic        pipe_flush_ack;
    logic [31:0] pipe_flush_add_op1;
    logic [31:0] pipe_flush_add_op2;
    logic        ifu_req_valid_raw;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic        ifu_rsp_valid;
    logic        ifu_rsp_drop;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush_busy;
`ifdef E203_IFU_FLUSH_PC_IN_EN
    logic [31:0] pipe_flush_pc;
    assign pipe_flush_pc = pipe_flush_add_op1 + pipe_flush_add_op2;
`endif

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    e203_ifu_flush_rsp dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .pipe_flush_req     (pipe_flush_req),
        .pipe_flush_ack     (pipe_flush_ack),
        .pipe_flush_add_op1 (pipe_flush_add_op1),
        .pipe_flush_add_op2 (pipe_flush_add_op2),
`ifdef E203_IFU_FLUSH_PC_IN_EN
        .pipe_flush_pc      (pipe_flush_pc),
`endif
        .ifu_req_valid_raw  (ifu_req_valid_raw),
        .ifu_req_valid      (ifu_req_valid),
        .ifu_req_ready      (ifu_req_ready),
        .ifu_rsp_valid      (ifu_rsp_valid),
        .ifu_rsp_drop       (ifu_rsp_drop),
        .redirect_valid     (redirect_valid),
        .redirect_pc        (redirect_pc),
        .flush_busy         (flush_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // outputs settle #1 after inputs change, well away from the edges
    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n              = 1'b0;
        pipe_flush_req     = 1'b0;
        pipe_flush_add_op1 = 32'h0;
        pipe_flush_add_op2 = 32'h0;
        ifu_req_valid_raw  = 1'b1;
        ifu_req_ready      = 1'b0;
        ifu_rsp_valid      = 1'b0;
        #12;
        // reset values
        check("rst_ack",   {31'd0, pipe_flush_ack}, 32'd1);
        check("rst_reqv",  {31'd0, ifu_req_valid},  32'd1);
        check("rst_rv",    {31'd0, redirect_valid}, 32'd0);
        check("rst_pc",    redirect_pc,             32'h0);
        check("rst_busy",  {31'd0, flush_busy},     32'd0);
        check("rst_drop",  {31'd0, ifu_rsp_drop},   32'd0);
        ifu_req_valid_raw = 1'b0;
        rst_n = 1'b1;
        tick();

        // idle flush: 0x1000 + 4
        pipe_flush_req = 1'b1; pipe_flush_add_op1 = 32'h0000_1000; pipe_flush_add_op2 = 32'h0000_0004;
        settle();
        check("idle_ack", {31'd0, pipe_flush_ack}, 32'd1);
        tick();
        pipe_flush_req = 1'b0;
        settle();
        check("idle_rv",   {31'd0, redirect_valid}, 32'd1);
        check("idle_pc",   redirect_pc,             32'h0000_1004);
        check("redir_ack", {31'd0, pipe_flush_ack}, 32'd0);
        check("redir_busy",{31'd0, flush_busy},     32'd1);
        tick();
        check("idle_rv_off", {31'd0, redirect_valid}, 32'd0);
        check("idle_busy_off", {31'd0, flush_busy}, 32'd0);

        // wrap and alignment
        pipe_flush_req = 1'b1; pipe_flush_add_op1 = 32'h0000_1000; pipe_flush_add_op2 = 32'hFFFF_FFFD;
        tick();
        pipe_flush_req = 1'b0;
        settle();
        check("wrap_rv", {31'd0, redirect_valid}, 32'd1);
        check("wrap_pc", redirect_pc,             32'h0000_0FFC);
        tick();

        // drain of 2 outstanding
        ifu_req_valid_raw = 1'b1; ifu_req_ready = 1'b1;
        settle();
        check("drn_reqv0", {31'd0, ifu_req_valid}, 32'd1);
        tick();
        tick();
        ifu_req_ready = 1'b0;
        pipe_flush_req = 1'b1; pipe_flush_add_op1 = 32'h0000_2000; pipe_flush_add_op2 = 32'h0000_0010;
        settle();
        check("drn_reqv_gate", {31'd0, ifu_req_valid}, 32'd0);
        tick();
        pipe_flush_req = 1'b0;
        settle();
        check("drn_busy",  {31'd0, flush_busy},     32'd1);
        check("drn_rv0",   {31'd0, redirect_valid}, 32'd0);
        check("drn_reqv1", {31'd0, ifu_req_valid},  32'd0);
        ifu_rsp_valid = 1'b1;
        settle();
        check("drn_drop1", {31'd0, ifu_rsp_drop}, 32'd1);
        tick();
        check("drn_rv1",   {31'd0, redirect_valid}, 32'd0);
        check("drn_drop2", {31'd0, ifu_rsp_drop},   32'd1);
        tick();
        ifu_rsp_valid = 1'b0; ifu_req_valid_raw = 1'b0;
        settle();
        check("drn_rv2", {31'd0, redirect_valid}, 32'd1);
        check("drn_pc",  redirect_pc,             32'h0000_2010);
        tick();

        // double flush: last one wins
        ifu_req_valid_raw = 1'b1; ifu_req_ready = 1'b1;
        tick();
        ifu_req_valid_raw = 1'b0; ifu_req_ready = 1'b0;
        pipe_flush_req = 1'b1; pipe_flush_add_op1 = 32'h0000_0100; pipe_flush_add_op2 = 32'h0;
        tick();
        pipe_flush_add_op1 = 32'h0000_0200;
        settle();
        check("dbl_ack_drain", {31'd0, pipe_flush_ack}, 32'd1);
        tick();
        pipe_flush_req = 1'b0;
        check("dbl_rv0", {31'd0, redirect_valid}, 32'd0);
        ifu_rsp_valid = 1'b1;
        tick();
        ifu_rsp_valid = 1'b0;
        check("dbl_rv1", {31'd0, redirect_valid}, 32'd1);
        check("dbl_pc",  redirect_pc,             32'h0000_0200);
        tick();
        check("dbl_single", {31'd0, redirect_valid}, 32'd0);

        // saturation and simultaneous events
        ifu_req_valid_raw = 1'b1; ifu_req_ready = 1'b1;
        tick(); tick(); tick();
        check("sat_reqv", {31'd0, ifu_req_valid}, 32'd0);
        ifu_rsp_valid = 1'b1;
        settle();
        check("idle_nodrop", {31'd0, ifu_rsp_drop}, 32'd0);
        tick();                      // count 3 -> 2
        check("sat_reqv2", {31'd0, ifu_req_valid}, 32'd1);
        tick();                      // accept + response: stays 2
        ifu_rsp_valid = 1'b0;
        settle();
        check("same_cyc_reqv", {31'd0, ifu_req_valid}, 32'd1);
        tick();                      // accept only: 2 -> 3
        check("sat_reqv3", {31'd0, ifu_req_valid}, 32'd0);
        ifu_req_valid_raw = 1'b0; ifu_req_ready = 1'b0;

        // flush with a same-cycle response, then async reset during DRAIN
        pipe_flush_req = 1'b1; pipe_flush_add_op1 = 32'h0000_0400; pipe_flush_add_op2 = 32'h0;
        ifu_rsp_valid = 1'b1;
        settle();
        check("hsk_drop", {31'd0, ifu_rsp_drop}, 32'd1);
        tick();
        pipe_flush_req = 1'b0; ifu_rsp_valid = 1'b0;
        check("pre_rst_busy", {31'd0, flush_busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, flush_busy},     32'd0);
        check("arst_rv",   {31'd0, redirect_valid}, 32'd0);
        check("arst_pc",   redirect_pc,             32'h0);
        check("arst_ack",  {31'd0, pipe_flush_ack}, 32'd1);
        check("arst_drop", {31'd0, ifu_rsp_drop},   32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_rv", {31'd0, redirect_valid}, 32'd0);
        pipe_flush_req = 1'b1; pipe_flush_add_op1 = 32'h0000_0300; pipe_flush_add_op2 = 32'h0000_0001;
        tick();
        pipe_flush_req = 1'b0;
        check("post_rst_flush_rv", {31'd0, redirect_valid}, 32'd1);
        check("post_rst_flush_pc", redirect_pc,             32'h0000_0300);
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // hard time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1);
    end

endmodule
